// File: rtl/hex_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table,
// blank pattern and drive polarity, plus a nibble-to-glyph helper.
package hex_scan_driver_pkg;

   // Segment and anode drives are active-low: 0 lights the element.
   localparam logic SEG_LIT  = 1'b0;
   localparam logic SEG_DARK = 1'b1;

   // All seven segments off.
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Hex glyphs, bit 0 = top segment, bits 1..5 clockwise, bit 6 = centre.
   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
      7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
      7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
      7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
   };

   function automatic logic [6:0] glyph_lookup(input logic [3:0] nibble);
      return GLYPH_TABLE[nibble];
   endfunction

endpackage

// File: rtl/hex_scan_driver_if.sv
// Bundle between the register side (value/load/controls) and the
// display pins (seg/dp/anodes/frame tick).
interface hex_scan_driver_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] value;
   logic                load;
   logic                blank_lz;
   logic [DIGITS-1:0]   blink_en;
   logic [DIGITS-1:0]   dp;
   logic [6:0]          seg;
   logic                dp_out;
   logic [DIGITS-1:0]   an;
   logic                frame_tick;

   // Register/host side: drives the display request, observes the pins.
   modport master (
      output value, load, blank_lz, blink_en, dp,
      input  seg, dp_out, an, frame_tick
   );

   // Driver side: consumes the request, drives the pins.
   modport slave (
      input  value, load, blank_lz, blink_en, dp,
      output seg, dp_out, an, frame_tick
   );
endinterface

// File: rtl/hex_scan_driver_glyph.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module hex_glyph
   import hex_scan_driver_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Table lookup of the glyph for the selected nibble.
   always_comb begin
      seg = glyph_lookup(nibble);
   end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver. Each digit owns a
// slot of REFRESH_DIV cycles; slot cycle 0 is a dead cycle with every
// anode off, during which the segment register is reloaded for the
// digit about to be lit. Supports leading-zero blanking, blink and dp.
module hex_scan_driver
   import hex_scan_driver_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 64
) (
   input  logic               clk,
   input  logic               rst,
   hex_scan_driver_if.slave   bus
);

   localparam int SCW = $clog2(REFRESH_DIV);
   localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [SCW-1:0] SLOT_LAST  = SCW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0]  IDX_TOP    = IW'(DIGITS - 1);
   localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);

   // Scan position
   logic [SCW-1:0]        slot_r;
   logic [IW-1:0]         digit_r;
   logic [SCW-1:0]        slot_nxt_s;
   logic [IW-1:0]         digit_nxt_s;

   // Shadow copies of the display request
   logic [4*DIGITS-1:0]   value_r;
   logic [DIGITS-1:0]     blink_sh_r;
   logic [DIGITS-1:0]     dp_sh_r;

   // Blink timing
   logic [BCW-1:0]        blink_cnt_r;
   logic                  blink_phase_r;

   // Output registers
   logic [6:0]            seg_r;
   logic                  dp_out_r;
   logic [DIGITS-1:0]     an_r;
   logic                  frame_tick_r;

   // Current-digit selection and blanking
   logic [3:0]            nibble_s;
   logic [6:0]            glyph_s;
   logic                  cur_blink_s;
   logic                  cur_dp_s;
   logic                  cur_lz_s;
   logic                  zero_above_s;
   logic                  hit_s;
   logic                  blank_s;
   logic [DIGITS-1:0]     an_nxt_s;

   hex_glyph u_glyph (
      .nibble (nibble_s),
      .seg    (glyph_s)
   );

   // Next scan position: slot counter wraps, digit index walks downward.
   always_comb begin
      slot_nxt_s  = slot_r;
      digit_nxt_s = digit_r;
      if (slot_r == SLOT_LAST) begin
         slot_nxt_s = '0;
         if (digit_r == '0) begin
            digit_nxt_s = IDX_TOP;
         end else begin
            digit_nxt_s = digit_r - IW'(1'b1);
         end
      end else begin
         slot_nxt_s  = slot_r + SCW'(1'b1);
         digit_nxt_s = digit_r;
      end
   end

   // Select the current digit's shadow fields, its leading-zero status and
   // the anode pattern for the next cycle (dark in the dead cycle).
   always_comb begin
      nibble_s     = 4'h0;
      cur_blink_s  = 1'b0;
      cur_dp_s     = 1'b0;
      cur_lz_s     = 1'b0;
      zero_above_s = 1'b1;
      hit_s        = 1'b0;
      an_nxt_s     = {DIGITS{SEG_DARK}};
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_above_s = zero_above_s & (value_r[4*i +: 4] == 4'h0);
         hit_s        = (IW'(i) == digit_r);
         nibble_s     = hit_s ? value_r[4*i +: 4] : nibble_s;
         cur_blink_s  = hit_s ? blink_sh_r[i] : cur_blink_s;
         cur_dp_s     = hit_s ? dp_sh_r[i] : cur_dp_s;
         cur_lz_s     = hit_s ? (zero_above_s && (i != 0)) : cur_lz_s;
         if ((IW'(i) == digit_nxt_s) && (slot_nxt_s != '0)) begin
            an_nxt_s[i] = SEG_LIT;
         end else begin
            an_nxt_s[i] = SEG_DARK;
         end
      end
      blank_s = (bus.blank_lz & cur_lz_s) | (blink_phase_r & cur_blink_s);
   end

   // Slot counter and digit index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_r  <= '0;
         digit_r <= IDX_TOP;
      end else begin
         slot_r  <= slot_nxt_s;
         digit_r <= digit_nxt_s;
      end
   end

   // Shadow registers capture the request on load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_r    <= '0;
         blink_sh_r <= '0;
         dp_sh_r    <= '0;
      end else if (bus.load) begin
         value_r    <= bus.value;
         blink_sh_r <= bus.blink_en;
         dp_sh_r    <= bus.dp;
      end else begin
         value_r    <= value_r;
         blink_sh_r <= blink_sh_r;
         dp_sh_r    <= dp_sh_r;
      end
   end

   // Blink phase flips every BLINK_DIV completed frames.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt_r   <= '0;
         blink_phase_r <= 1'b0;
      end else if (frame_tick_r) begin
         if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= ~blink_phase_r;
         end else begin
            blink_cnt_r   <= blink_cnt_r + BCW'(1'b1);
            blink_phase_r <= blink_phase_r;
         end
      end else begin
         blink_cnt_r   <= blink_cnt_r;
         blink_phase_r <= blink_phase_r;
      end
   end

   // Output registers; segments reload in the dead cycle so a digit keeps
   // its glyph for the whole lit part of its slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_r        <= SEG_BLANK;
         dp_out_r     <= SEG_DARK;
         an_r         <= {DIGITS{SEG_DARK}};
         frame_tick_r <= 1'b0;
      end else begin
         an_r         <= an_nxt_s;
         frame_tick_r <= (slot_nxt_s == SLOT_LAST) && (digit_nxt_s == '0);
         if (slot_r == '0) begin
            if (blank_s) begin
               seg_r    <= SEG_BLANK;
               dp_out_r <= SEG_DARK;
            end else begin
               seg_r    <= glyph_s;
               dp_out_r <= cur_dp_s ? SEG_LIT : SEG_DARK;
            end
         end else begin
            seg_r    <= seg_r;
            dp_out_r <= dp_out_r;
         end
      end
   end

   assign bus.seg        = seg_r;
   assign bus.dp_out     = dp_out_r;
   assign bus.an         = an_r;
   assign bus.frame_tick = frame_tick_r;

endmodule
